req_encoder_16_to_4: RTL and testbench
======================================

# req_encoder_16_to_4

Sequential 16-to-4 request encoder that sits at the opposite end of the 4-to-16 decode path. It collects 16 request lines into a sticky pending register and presents one winning index at a time as a 4-bit code with a valid/ack handshake. Each acknowledged request is retired before the next index is offered. Its output code uses the same bit-to-index mapping as the team's 4-to-16 decoder: q[i] corresponds to d = i. A code from this block can therefore drive that decoder directly to regenerate a one-hot grant.

## Interface
No parameters; all widths are fixed.
- clk  input  1  system clock; all state updates on rising edge
- reset_n  input  1  synchronous, active-low reset, sampled on rising clk
- req  input  16  request lines, level-sampled every cycle; any number may be high
- ack  input  1  consumer accepts current code; meaningful only while valid=1
- code  output  4  index of the granted request; registered
- valid  output  1  code is valid and held stable until ack
- pending  output  16  registered sticky pending-request vector
- pend_cnt  output  5  registered population count of pending, range 0..16

## Operation
- Reset (reset_n=0 at an edge): state=IDLE, pending=0, code=0, valid=0, pend_cnt=0, RR pointer=15.
- Pending update, every edge: pending_next = (pending & ~clr) | req.
  - clr is the one-hot of code when ack is accepted, otherwise 0.
  - Set wins over clear. If req[code] is high in the ack cycle, that bit stays pending and will be granted again later.
- pend_cnt = popcount(pending_next), registered together with pending.
- FSM states: IDLE, GRANT, RETIRE.
  - IDLE: if registered pending≠0, latch code=winner(pending), set valid=1, go to GRANT. Otherwise stay in IDLE.
  - GRANT: valid=1 and code is held. On ack=1, clear pending[code], set valid=0, go to RETIRE.
  - RETIRE: valid=0 for exactly one cycle. Then behave as IDLE on the following edge, evaluated on the updated pending.
- Winner, fixed priority: lowest set index (bit 0 highest priority).
- ack while valid=0 is ignored and has no state change.
- req bits already pending have no additional effect; requests are not counted, only flagged.

## Timing
- Latency: req high at edge E0 → pending bit set after E0 → code/valid registered at E1 → valid high during the cycle after E1. That is 2 edges from sample to valid.
- Handshake: code is stable for every cycle valid=1; transfer completes on the edge where valid=1 and ack=1.
- Back-to-back: ack at edge Ea → valid low after Ea (RETIRE) → next grant latched at Ea+1. This gives a minimum 1-cycle valid-low gap between grants and a throughput of 1 grant per 2 cycles.
- ack held high continuously: one grant per 2 cycles, no grant skipped.
- All 16 pending: pend_cnt=16 (5'b10000); drains in 16 grants.
- Reset mid-GRANT: valid=0 and pending=0 after the reset edge. Requests sampled in the reset cycle are discarded.
- Outputs change only on clk edges; no combinational path from req or ack to any output.

## Configuration
- ROUND_ROBIN_EN defined: winner is the first set bit searching from (ptr+1) mod 16 upward, wrapping through 15→0.
  - ptr is loaded with the granted code on each accepted ack; ptr reset value is 15, so the first search starts at bit 0.
- ROUND_ROBIN_EN undefined: fixed lowest-index priority, and no pointer register exists.
- Handshake, latency and pending rules are identical in both builds.

## Test plan
- Reset then req=16'h0000 for 10 cycles → valid=0, code=0, pend_cnt=0 throughout.
- Single pulse req=16'h0100 for one cycle, ack held 0 → valid high 2 edges later with code=4'd8 and pend_cnt=1. Code and valid hold for 5 cycles; ack → valid=0, pending=0, pend_cnt=0.
- req=16'h8421 pulse, ack held 1 → fixed build grants codes 0, 5, 10, 15 with exactly one valid-low cycle between each. pend_cnt steps 4→3→2→1→0.
- ROUND_ROBIN_EN:
  - Grant code 0 with req[0] held high.
  - Also pend bit 3 → next grant is 3, not 0.
  - Then 0 again, since the search wraps.
- Set-wins: while code=2 is valid, drive req[2]=1 in the ack cycle → pending[2] stays 1, and code=2 is granted again after RETIRE.
- Reset mid-operation: req=16'hFFFF, reset_n=0 during GRANT → next edge valid=0, pending=0, pend_cnt=0. ack asserted while valid=0 has no effect.

Source files
------------

// File: rtl/req_encoder_16_to_4.sv
// req_encoder_16_to_4
// Collects 16 request lines into a sticky pending vector and offers one
// winning index at a time as a 4-bit code with a valid/ack handshake.
// code value i selects pending[i], matching the 4-to-16 decoder mapping.
// Build option: ROUND_ROBIN_EN selects a rotating search that starts one
// past the last accepted code; undefined gives fixed lowest-index priority.
//
// state  | meaning
// IDLE   | nothing offered; grant on the next edge if anything is pending
// GRANT  | valid=1, code held until ack
// RETIRE | one valid-low cycle after an accepted ack; then acts as IDLE
module req_encoder_16_to_4 (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] req,
   input  logic        ack,
   output logic [3:0]  code,
   output logic        valid,
   output logic [15:0] pending,
   output logic [4:0]  pend_cnt
);

   typedef enum logic [1:0] {IDLE, GRANT, RETIRE} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  code_nxt;
   logic        valid_nxt;
   logic [15:0] clr;
   logic [15:0] pending_nxt;
   logic [4:0]  cnt_nxt;
   logic [3:0]  winner;
   logic        win_found;

`ifdef ROUND_ROBIN_EN
   logic [3:0]  ptr;
   logic [3:0]  rr_idx;

   // Rotating search from ptr+1 upward; the 4-bit add wraps 15 -> 0.
   always_comb begin
      winner    = 4'd0;
      win_found = 1'b0;
      rr_idx    = 4'd0;
      for (int i = 1; i <= 16; i++) begin
         rr_idx = ptr + 4'(i);
         if (!win_found && pending[rr_idx]) begin
            winner    = rr_idx;
            win_found = 1'b1;
         end
      end
   end

   // Pointer remembers the last accepted code so the next search starts past it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ptr <= 4'd15;
      end else if (state == GRANT && ack) begin
         ptr <= code;
      end
   end
`else
   // Fixed priority: lowest set index wins.
   always_comb begin
      winner    = 4'd0;
      win_found = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (!win_found && pending[i]) begin
            winner    = 4'(i);
            win_found = 1'b1;
         end
      end
   end
`endif

   // Next state, next registered outputs and the retire mask for an accepted ack.
   always_comb begin
      state_nxt = state;
      code_nxt  = code;
      valid_nxt = valid;
      clr       = 16'd0;
      case (state)
         IDLE, RETIRE: begin
            if (|pending) begin
               code_nxt  = winner;
               valid_nxt = 1'b1;
               state_nxt = GRANT;
            end else begin
               valid_nxt = 1'b0;
               state_nxt = IDLE;
            end
         end
         GRANT: begin
            if (ack) begin
               clr       = 16'd1 << code;
               valid_nxt = 1'b0;
               state_nxt = RETIRE;
            end
         end
         default: begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Set wins over clear so a request arriving in the ack cycle is not lost.
   always_comb begin
      pending_nxt = (pending & ~clr) | req;
      cnt_nxt     = 5'd0;
      for (int i = 0; i < 16; i++) begin
         cnt_nxt = cnt_nxt + 5'(pending_nxt[i]);
      end
   end

   // State and all outputs are registered; requests in a reset cycle are dropped.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         code     <= 4'd0;
         valid    <= 1'b0;
         pending  <= 16'd0;
         pend_cnt <= 5'd0;
      end else begin
         state    <= state_nxt;
         code     <= code_nxt;
         valid    <= valid_nxt;
         pending  <= pending_nxt;
         pend_cnt <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_req_encoder_16_to_4.sv
// Bench for req_encoder_16_to_4: directed vectors, a per-cycle reference
// model of the grant/retire behaviour, and literal spot checks.
module tb_req_encoder_16_to_4;

   logic        clk;
   logic        reset_n;
   logic [15:0] req;
   logic        ack;
   logic [3:0]  code;
   logic        valid;
   logic [15:0] pending;
   logic [4:0]  pend_cnt;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 0;

   logic [15:0] m_pend;
   logic        m_valid;
   logic [3:0]  m_code;
   logic [4:0]  m_cnt;
`ifdef ROUND_ROBIN_EN
   int          m_ptr;
`endif

   req_encoder_16_to_4 dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .ack      (ack),
      .code     (code),
      .valid    (valid),
      .pending  (pending),
      .pend_cnt (pend_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // First set bit of p scanning upward from start, wrapping modulo 16.
   function automatic logic [3:0] pick(input logic [15:0] p, input int start);
      int idx;
      for (int k = 0; k < 16; k++) begin
         idx = (start + k) % 16;
         if (p[idx]) return 4'(idx);
      end
      return 4'd0;
   endfunction

   // Reference: a grant is offered whenever nothing is valid, an ack retires it.
   always @(posedge clk) begin
      logic [15:0] m_clr;
      m_clr = 16'd0;
      if (!reset_n) begin
         m_pend  = 16'd0;
         m_valid = 1'b0;
         m_code  = 4'd0;
`ifdef ROUND_ROBIN_EN
         m_ptr   = 15;
`endif
      end else begin
         if (m_valid && ack) begin
            m_clr[m_code] = 1'b1;
            m_valid       = 1'b0;
`ifdef ROUND_ROBIN_EN
            m_ptr         = int'(m_code);
`endif
         end else if (!m_valid && m_pend != 16'd0) begin
`ifdef ROUND_ROBIN_EN
            m_code  = pick(m_pend, (m_ptr + 1) % 16);
`else
            m_code  = pick(m_pend, 0);
`endif
            m_valid = 1'b1;
         end
         m_pend = (m_pend & ~m_clr) | req;
      end
      m_cnt = 5'($countones(m_pend));
   end

   // Every cycle after the first reset edge the DUT must match the model.
   always @(negedge clk) begin
      if (chk_en) begin
         vectors++;
         if (code !== m_code || valid !== m_valid || pending !== m_pend || pend_cnt !== m_cnt) begin
            miscompares++;
            $display("FAIL model t=%0t: got code=%0d valid=%0b pending=%h cnt=%0d, expected code=%0d valid=%0b pending=%h cnt=%0d",
                     $time, code, valid, pending, pend_cnt, m_code, m_valid, m_pend, m_cnt);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [3:0] exp_codes [4];
   logic [3:0] rr_second;

   initial begin
      exp_codes[0] = 4'd0;
      exp_codes[1] = 4'd5;
      exp_codes[2] = 4'd10;
      exp_codes[3] = 4'd15;
`ifdef ROUND_ROBIN_EN
      rr_second = 4'd3;
`else
      rr_second = 4'd0;
`endif
      reset_n = 1'b0;
      req     = 16'd0;
      ack     = 1'b0;
      step();
      chk_en = 1;
      step();
      reset_n = 1'b1;

      // Idle with no requests.
      for (int i = 0; i < 10; i++) begin
         step();
         check("idle_valid", 16'(valid), 16'd0);
         check("idle_code", 16'(code), 16'd0);
         check("idle_cnt", 16'(pend_cnt), 16'd0);
      end

      // Single pulse on bit 8, held offer, then ack.
      req = 16'h0100;
      step();
      req = 16'h0000;
      check("pulse_e0_valid", 16'(valid), 16'd0);
      check("pulse_e0_cnt", 16'(pend_cnt), 16'd1);
      step();
      check("pulse_valid", 16'(valid), 16'd1);
      check("pulse_code", 16'(code), 16'd8);
      check("pulse_cnt", 16'(pend_cnt), 16'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_valid", 16'(valid), 16'd1);
         check("hold_code", 16'(code), 16'd8);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      check("ack_valid", 16'(valid), 16'd0);
      check("ack_pending", pending, 16'd0);
      check("ack_cnt", 16'(pend_cnt), 16'd0);
      step();

      // Four requests with ack held high: one grant every two cycles.
      req = 16'h8421;
      ack = 1'b1;
      step();
      req = 16'h0000;
      check("multi_cnt0", 16'(pend_cnt), 16'd4);
      for (int k = 0; k < 4; k++) begin
         step();
         check("multi_grant_valid", 16'(valid), 16'd1);
         check("multi_grant_code", 16'(code), 16'(exp_codes[k]));
         check("multi_grant_cnt", 16'(pend_cnt), 16'(4 - k));
         step();
         check("multi_gap_valid", 16'(valid), 16'd0);
         check("multi_gap_cnt", 16'(pend_cnt), 16'(3 - k));
      end
      ack = 1'b0;
      step();

      // Set wins over clear on the acked index.
      req = 16'h0004;
      step();
      req = 16'h0000;
      step();
      check("setwin_code", 16'(code), 16'd2);
      req = 16'h0004;
      ack = 1'b1;
      step();
      req = 16'h0000;
      ack = 1'b0;
      check("setwin_retire_valid", 16'(valid), 16'd0);
      check("setwin_pending", pending, 16'h0004);
      step();
      check("setwin_regrant_valid", 16'(valid), 16'd1);
      check("setwin_regrant_code", 16'(code), 16'd2);
      ack = 1'b1;
      step();
      ack = 1'b0;
      step();

      // Held bit 0 plus bit 3: rotation versus fixed priority.
      req = 16'h0001;
      step();
      step();
      check("rr_first", 16'(code), 16'd0);
      req = 16'h0009;
      ack = 1'b1;
      step();
      step();
      check("rr_second", 16'(code), 16'(rr_second));
      step();
      step();
      check("rr_third", 16'(code), 16'd0);
      req = 16'h0000;
      for (int i = 0; i < 6; i++) step();
      ack = 1'b0;
      check("rr_drained", 16'(pend_cnt), 16'd0);

      // All sixteen pending drain in sixteen grants.
      req = 16'hFFFF;
      step();
      req = 16'h0000;
      check("full_cnt", 16'(pend_cnt), 16'd16);
      ack = 1'b1;
      for (int i = 0; i < 33; i++) step();
      ack = 1'b0;
      check("full_drained", 16'(pend_cnt), 16'd0);
      check("full_valid", 16'(valid), 16'd0);

      // Reset in the middle of a grant.
      req = 16'hFFFF;
      step();
      step();
      check("pre_reset_valid", 16'(valid), 16'd1);
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      req = 16'h0000;
      check("reset_valid", 16'(valid), 16'd0);
      check("reset_pending", pending, 16'd0);
      check("reset_cnt", 16'(pend_cnt), 16'd0);
      ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stray_ack_valid", 16'(valid), 16'd0);
         check("stray_ack_pending", pending, 16'd0);
      end
      ack = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
